// File: rtl/pong_game_ctrl.sv
// Pong game controller: sequences new game, play, ball serve delay and game over.
// Latency: every output is registered and changes one clk edge after the input event that causes it.
// Backpressure: none; hit, miss and refr_tick are single-cycle pulses and are never queued or latched.
module pong_game_ctrl #(
    parameter int BALLS       = 3,
    parameter int TIMER_TICKS = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refr_tick,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    output logic       graph_still,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [1:0] balls_left,
    output logic       game_over,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [1:0] BALLS_INIT = 2'(BALLS - 1);
    localparam logic [6:0] TIMER_INIT = 7'(TIMER_TICKS);

    state_t     st;
    logic [6:0] timer;
    logic       timer_start;
    logic       timer_up;

    // The serve/over delay starts on the very cycle a ball is lost.
    assign timer_start = (st == PLAY) && miss;
    assign timer_up    = (timer == 7'd0);
    assign state       = st;

    // Two-digit BCD increment; 99 wraps to 00 without any carry out.
    function automatic logic [7:0] bcd_inc(input logic [3:0] d1, input logic [3:0] d0);
        logic [3:0] n1;
        logic [3:0] n0;
        n1 = d1;
        n0 = d0 + 4'd1;
        if (d0 == 4'd9) begin
            n0 = 4'd0;
            n1 = (d1 == 4'd9) ? 4'd0 : d1 + 4'd1;
        end
        return {n1, n0};
    endfunction

    // Frame-tick delay timer: a load beats a coincident tick, and it parks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= 7'd0;
        end else if (timer_start) begin
            timer <= TIMER_INIT;
        end else if (refr_tick && !timer_up) begin
            timer <= timer - 7'd1;
        end
    end

    // Game FSM with registered score, ball count and display-control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= NEWGAME;
            score_d1    <= 4'd0;
            score_d0    <= 4'd0;
            balls_left  <= BALLS_INIT;
            graph_still <= 1'b1;
            game_over   <= 1'b0;
        end else begin
            case (st)
                NEWGAME: begin
                    if (btn != 2'b00) begin
                        st          <= PLAY;
                        graph_still <= 1'b0;
                        balls_left  <= BALLS_INIT;
                        score_d1    <= 4'd0;
                        score_d0    <= 4'd0;
                    end
                end
                PLAY: begin
                    // A hit and a miss in the same cycle both take effect.
                    if (hit) begin
                        {score_d1, score_d0} <= bcd_inc(score_d1, score_d0);
                    end
                    if (miss) begin
                        graph_still <= 1'b1;
                        if (balls_left != 2'd0) begin
                            balls_left <= balls_left - 2'd1;
                            st         <= NEWBALL;
                        end else begin
                            st        <= OVER;
                            game_over <= 1'b1;
                        end
                    end
                end
                NEWBALL: begin
                    // Button presses during the delay are dropped, not remembered.
                    if (timer_up && (btn != 2'b00)) begin
                        st          <= PLAY;
                        graph_still <= 1'b0;
                    end
                end
                OVER: begin
                    if (timer_up) begin
                        st         <= NEWGAME;
                        game_over  <= 1'b0;
                        score_d1   <= 4'd0;
                        score_d0   <= 4'd0;
                        balls_left <= BALLS_INIT;
                    end
                end
                default: begin
                    st <= NEWGAME;
                end
            endcase
        end
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter: BALLS, 3, balls per game (1..3).
REQ-002 SHALL have parameter: TIMER_TICKS, 120, frame ticks for the serve/over delay (1..127; 2 s at 60 Hz).
REQ-003 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: refr_tick  input  1  one-cycle pulse per frame, from the pixel-position compare (pixel_y==481, pixel_x==0).
REQ-006 SHALL have port: btn  input  2  paddle buttons, synchronous, level.
REQ-007 SHALL have port: hit  input  1  one-cycle pulse, ball hit paddle.
REQ-008 SHALL have port: miss  input  1  one-cycle pulse, ball passed paddle.
REQ-009 SHALL have port: graph_still  output  1  freezes ball/paddle motion in the graphics generator.
REQ-010 SHALL have port: score_d1  output  4  BCD tens digit.
REQ-011 SHALL have port: score_d0  output  4  BCD ones digit.
REQ-012 SHALL have port: balls_left  output  2  balls remaining after the current one.
REQ-013 SHALL have port: game_over  output  1  high while in OVER.
REQ-014 SHALL have port: state  output  2  NEWGAME=00, PLAY=01, NEWBALL=10, OVER=11.

Function
REQ-015 SHALL implement a 4-state FSM: NEWGAME, PLAY, NEWBALL, OVER; state register updates only on clk.
REQ-016 SHALL implement a 7-bit delay timer: loaded with TIMER_TICKS on timer_start, decremented by 1 on each refr_tick while nonzero, holds at 0; timer_up = (timer==0).
REQ-017 NEWGAME: graph_still=1; score held at 00; balls_left=BALLS-1 once btn!=0 is accepted; on btn!=0 -> PLAY in the next cycle.
REQ-018 PLAY: graph_still=0; hit pulse increments the BCD score by 1 on the next edge; miss pulse -> NEWBALL if balls_left!=0 (balls_left decremented by 1 at that edge), else -> OVER; timer_start asserted on the miss cycle in both cases.
REQ-019 NEWBALL: graph_still=1; -> PLAY when timer_up=1 and btn!=0 in the same cycle; btn before timer_up is ignored (no latching).
REQ-020 OVER: graph_still=1, game_over=1; -> NEWGAME when timer_up=1; score cleared to 00 and balls_left reloaded to BALLS-1 at that edge.
REQ-021 Score arithmetic: d0 0..9; d0=9 plus hit -> d0=0 with d1+1; 99 plus hit -> 00 (wrap, no flag).
REQ-022 hit/miss outside PLAY SHALL be ignored (no score, balls or state change).
REQ-023 hit and miss in the same PLAY cycle: score increments AND the miss transition is taken.
REQ-024 refr_tick coincident with a timer load: load wins (timer=TIMER_TICKS).
REQ-025 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-026 rst=1 SHALL immediately (without clk) force state=NEWGAME, score_d1=score_d0=0, balls_left=BALLS-1, timer=0, graph_still=1, game_over=0.
REQ-027 rst asserted mid-PLAY or mid-delay SHALL abandon the game; first edge after release evaluates NEWGAME rules.

Verification
REQ-028 Reset, btn=01 one cycle -> state=PLAY next edge, graph_still=0, score=00, balls_left=2.
REQ-029 In PLAY, 12 hit pulses -> score_d1=1, score_d0=2; 100 hits from 00 -> 00.
REQ-030 In PLAY with balls_left=2, miss -> NEWBALL, balls_left=1; btn held during 119 refr_ticks -> stays NEWBALL; after 120th tick with btn=10 -> PLAY.
REQ-031 balls_left=0, miss -> OVER, game_over=1; after 120 refr_ticks -> NEWGAME, score=00, balls_left=2, game_over=0.
REQ-032 Simultaneous hit+miss in PLAY (score 09, balls_left=1) -> score 10, NEWBALL, balls_left=0; hit in NEWBALL -> score unchanged.
REQ-033 rst pulsed between clk edges during OVER with timer=50 -> outputs at reset values before next edge, state=NEWGAME.
